// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - scrolls/respawns pipe obstacles, tracks score/collision, feeds tile coords to the sprite ROM
// Optional feature macro PIPE_SPEEDUP_EN: scroll speed grows with score.
module pipe_scheduler #(
  parameter int          NUM_PIPES = 3,
  parameter int          SCR_W     = 640,
  parameter int          SCR_H     = 480,
  parameter int          PIPE_W    = 32,
  parameter int          GAP_H     = 128,
  parameter int          GAP_MIN   = 64,
  parameter int          SPACING   = 224,
  parameter int          SPEED     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [10:0] px,
  input  logic [10:0] py,
  input  logic [10:0] bird_x,
  input  logic [10:0] bird_y,
  output logic [10:0] tile_x,
  output logic [10:0] tile_y,
  output logic        pipe_hit,
  output logic        collide,
  output logic [7:0]  score,
  output logic [1:0]  state
);

  localparam int CW = $clog2(NUM_PIPES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t st_q, st_d;
  logic   do_step, do_crash, do_scroll, do_reinit;

  logic [10:0]   xr_q  [NUM_PIPES];
  logic [8:0]    gap_q [NUM_PIPES];
  logic [10:0]   xr_n  [NUM_PIPES];
  logic [8:0]    gap_n [NUM_PIPES];
  logic [15:0]   lfsr_q;
  logic [11:0]   spd;
  logic [11:0]   bx, by, px12, py12;
  logic          hit_any;
  logic [CW-1:0] pass_cnt;
  logic [8:0]    score_sum;
  logic          hit_c, hit1;
  logic [3:0]    tx_c;

  // Everything is compared in 12 bits so sums like px+PIPE_W never wrap.
  assign bx    = {1'b0, bird_x};
  assign by    = {1'b0, bird_y};
  assign px12  = {1'b0, px};
  assign py12  = {1'b0, py};
  assign state = st_q;

  always_ff @(posedge clk) begin
    if (rst) st_q <= S_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (start) st_d = S_RUN;
      S_RUN:   if (frame_tick && hit_any) st_d = S_OVER;
      S_OVER:  if (start) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_step   = 1'b0;
    do_crash  = 1'b0;
    do_scroll = 1'b0;
    do_reinit = 1'b0;
    case (st_q)
      S_RUN: begin
        do_step   = frame_tick;
        do_crash  = frame_tick && hit_any;
        do_scroll = frame_tick && !hit_any;
      end
      S_OVER:  do_reinit = start;
      default: ;
    endcase
  end

  // Collision uses pre-move positions; the body test is rearranged to avoid xr-PIPE_W underflow.
  always_comb begin
    hit_any = (by + 12'd16) > 12'(SCR_H);
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (bx < {1'b0, xr_q[i]} &&
          (bx + 12'(16 + PIPE_W)) > {1'b0, xr_q[i]} &&
          (by < {3'b0, gap_q[i]} ||
           (by + 12'd16) > ({3'b0, gap_q[i]} + 12'(GAP_H))))
        hit_any = 1'b1;
    end
  end

`ifdef PIPE_SPEEDUP_EN
  always_comb begin
    spd = 12'(SPEED) + ((score[7:4] > 4'd2) ? 12'd2 : {8'd0, score[7:4]});
  end
`else
  assign spd = 12'(SPEED);
`endif

  always_comb begin
    logic [11:0] xo, xn;
    xo       = '0;
    xn       = '0;
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      xo       = {1'b0, xr_q[i]};
      gap_n[i] = gap_q[i];
      if (xo <= spd) begin
        xn       = xo - spd + 12'(NUM_PIPES * SPACING);
        gap_n[i] = 9'(GAP_MIN) + {1'b0, lfsr_q[7:0] ^ 8'(i)};
      end else begin
        xn = xo - spd;
      end
      xr_n[i] = xn[10:0];
      if (xo > bx && xn <= bx)
        pass_cnt = pass_cnt + CW'(1);
    end
    score_sum = {1'b0, score} + 9'(pass_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst || do_reinit) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        xr_q[i]  <= 11'(SCR_W + PIPE_W + i * SPACING);
        gap_q[i] <= 9'(GAP_MIN + 64 * i);
      end
      lfsr_q  <= LFSR_SEED;
      score   <= '0;
      collide <= 1'b0;
    end else begin
      if (do_step)
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      if (do_crash)
        collide <= 1'b1;
      if (do_scroll) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          xr_q[i]  <= xr_n[i];
          gap_q[i] <= gap_n[i];
        end
        score <= score_sum[8] ? 8'hFF : score_sum[7:0];
      end
    end
  end

  // Lowest-index pipe wins; only the low nibble of px+PIPE_W-xr reaches the ROM.
  always_comb begin
    hit_c = 1'b0;
    tx_c  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (!hit_c && px12 < {1'b0, xr_q[i]} &&
          (px12 + 12'(PIPE_W)) >= {1'b0, xr_q[i]} &&
          (py12 < {3'b0, gap_q[i]} ||
           py12 >= ({3'b0, gap_q[i]} + 12'(GAP_H)))) begin
        hit_c = 1'b1;
        tx_c  = px[3:0] + 4'(PIPE_W) - xr_q[i][3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_x   <= '0;
      tile_y   <= '0;
      hit1     <= 1'b0;
      pipe_hit <= 1'b0;
    end else begin
      tile_x   <= {7'b0, tx_c};
      tile_y   <= hit_c ? {7'b0, py[3:0]} : 11'd0;
      hit1     <= hit_c;
      pipe_hit <= hit1;
    end
  end

endmodule
